// File: rtl/int2fp_pkg.sv
// int2fp_pkg: shared state type and width helpers for the integer-to-float converter
package int2fp_pkg;
  typedef enum logic [2:0] {IDLE, ABS, NORM, PACK, DONE} int2fp_state_t;
  function automatic int int2fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
  function automatic int int2fp_out_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction
endpackage

// File: rtl/int2fp_if.sv
// int2fp_if: integer-in / float-out valid-ready channels
interface int2fp_if #(parameter int IN_W = 16, parameter int OUT_W = 16);
  logic in_valid, in_ready, out_valid, out_ready, out_overflow, out_inexact;
  logic [IN_W-1:0] in_data;
  logic [OUT_W-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_overflow, out_inexact);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_overflow, out_inexact);
endinterface

// File: rtl/int2fp_round_pack.sv
// int2fp_round_pack: rounds a normalised magnitude and packs sign/exponent/fraction; INT2FP_ROUND_NEAREST_EN selects RNE over truncation
module int2fp_round_pack
  import int2fp_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int SH_W = 4,
  localparam int OUT_W = int2fp_out_w(EXP_W, MAN_W)
) (
  input  logic             sign,
  input  logic [IN_W-1:0]  mag,
  input  logic [SH_W-1:0]  sh,
  input  logic             zero,
  output logic [OUT_W-1:0] data,
  output logic             overflow,
  output logic             inexact
);
  localparam int BIAS = int2fp_bias(EXP_W);
  localparam int EXT_W = IN_W + MAN_W + 1;
  logic [EXT_W-1:0] ext;
  logic [MAN_W-1:0] frac;
  logic [MAN_W:0] frac_r;
  logic lead, g, s, inc;
  logic [31:0] exp_b;
  // ext holds the hidden-bit-stripped magnitude above MAN_W+2 zeros so guard/sticky always exist
  always_comb begin
    lead = mag[IN_W-1] & ~zero;
    ext = {mag[IN_W-2:0], {(MAN_W + 2){1'b0}}};
    frac = ext[EXT_W-1 -: MAN_W];
    g = ext[IN_W];
    s = |ext[IN_W-1:0];
`ifdef INT2FP_ROUND_NEAREST_EN
    inc = g & (s | frac[0]);
`else
    inc = 1'b0;
`endif
    frac_r = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
    exp_b = 32'(IN_W - 1 + BIAS) - 32'(sh) + 32'(frac_r[MAN_W]);
    overflow = lead & (exp_b >= 32'((1 << EXP_W) - 1));
    inexact = lead & (overflow | g | s);
    data = !lead ? '0 : overflow ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sign, exp_b[EXP_W-1:0], frac_r[MAN_W-1:0]};
  end
endmodule

// File: rtl/int2fp_conv.sv
// int2fp_conv: multi-cycle integer to IEEE-754 converter with serial normalisation; rounding mode set by INT2FP_ROUND_NEAREST_EN
module int2fp_conv
  import int2fp_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int SIGNED = 1,
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic     clk,
  input logic     reset,
  int2fp_if.slave bus
);
  localparam int SH_W = $clog2(IN_W);
  localparam int OUT_W = int2fp_out_w(EXP_W, MAN_W);
  int2fp_state_t state;
  logic [IN_W-1:0] in_q, mag;
  logic [SH_W-1:0] sh;
  logic sign, zero, neg, pk_ovf, pk_inx;
  logic [OUT_W-1:0] pk_data;
  assign neg = (SIGNED != 0) && in_q[IN_W-1];
  assign bus.in_ready = state == IDLE;
  int2fp_round_pack #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W), .SH_W(SH_W)) u_round_pack (
    .sign, .mag, .sh, .zero, .data(pk_data), .overflow(pk_ovf), .inexact(pk_inx)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_overflow <= 1'b0;
      bus.out_inexact <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.in_valid) begin
          in_q <= bus.in_data;
          state <= ABS;
        end
        ABS: begin
          sign <= neg;
          mag <= neg ? -in_q : in_q;
          sh <= '0;
          zero <= in_q == '0;
          state <= in_q == '0 ? PACK : NORM;
        end
        NORM: if (mag[IN_W-1]) state <= PACK;
          else begin
            mag <= mag << 1;
            sh <= sh + 1'b1;
          end
        PACK: begin
          bus.out_data <= pk_data;
          bus.out_overflow <= pk_ovf;
          bus.out_inexact <= pk_inx;
          bus.out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_int2fp_conv.sv
// tb_int2fp_conv: directed vectors for signed-16, unsigned-16 and signed-32 converter instances
module tb_int2fp_conv;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
`ifdef INT2FP_ROUND_NEAREST_EN
  localparam logic [15:0] R32767 = 16'h7800, R2051 = 16'h6802, R65520 = 16'h7C00, RUFFFF = 16'h7C00;
  localparam logic OV_RN = 1'b1;
`else
  localparam logic [15:0] R32767 = 16'h77FF, R2051 = 16'h6801, R65520 = 16'h7BFF, RUFFFF = 16'h7BFF;
  localparam logic OV_RN = 1'b0;
`endif
  typedef struct {
    int u;
    logic [31:0] d;
    logic [15:0] data;
    logic ovf;
    logic inx;
    int lat;
  } vec_t;
  logic iv[3], ordy[3], ovld[3], oof[3], oix[3], ird[3];
  logic [31:0] idat[3];
  logic [15:0] od[3];
  int total = 0, passed = 0, lat;
  int2fp_if #(.IN_W(16), .OUT_W(16)) b0 ();
  int2fp_if #(.IN_W(16), .OUT_W(16)) b1 ();
  int2fp_if #(.IN_W(32), .OUT_W(16)) b2 ();
  int2fp_conv #(.IN_W(16), .SIGNED(1)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  int2fp_conv #(.IN_W(16), .SIGNED(0)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  int2fp_conv #(.IN_W(32), .SIGNED(1)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  assign b0.in_valid = iv[0];
  assign b1.in_valid = iv[1];
  assign b2.in_valid = iv[2];
  assign b0.in_data = idat[0][15:0];
  assign b1.in_data = idat[1][15:0];
  assign b2.in_data = idat[2];
  assign b0.out_ready = ordy[0];
  assign b1.out_ready = ordy[1];
  assign b2.out_ready = ordy[2];
  assign ovld[0] = b0.out_valid;
  assign ovld[1] = b1.out_valid;
  assign ovld[2] = b2.out_valid;
  assign od[0] = b0.out_data;
  assign od[1] = b1.out_data;
  assign od[2] = b2.out_data;
  assign oof[0] = b0.out_overflow;
  assign oof[1] = b1.out_overflow;
  assign oof[2] = b2.out_overflow;
  assign oix[0] = b0.out_inexact;
  assign oix[1] = b1.out_inexact;
  assign oix[2] = b2.out_inexact;
  assign ird[0] = b0.in_ready;
  assign ird[1] = b1.in_ready;
  assign ird[2] = b2.in_ready;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endtask
  // offers one sample, then counts edges after the accepting edge until out_valid is seen
  task automatic start(input int u, input logic [31:0] d, output int n);
    @(negedge clk);
    idat[u] = d;
    iv[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[u] = 1'b0;
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ovld[u]) break;
    end
  endtask
  task automatic take(input int u);
    ordy[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[u] = 1'b0;
  endtask
  initial begin
    vec_t tbl[$];
    logic seen;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0;
      ordy[k] = 1'b0;
      idat[k] = '0;
    end
    tbl.push_back('{0, 32'h0001, 16'h3C00, 1'b0, 1'b0, 18});
    tbl.push_back('{0, 32'hFFFB, 16'hC500, 1'b0, 1'b0, 16});
    tbl.push_back('{0, 32'h8000, 16'hF800, 1'b0, 1'b0, 3});
    tbl.push_back('{0, 32'h0000, 16'h0000, 1'b0, 1'b0, 2});
    tbl.push_back('{0, 32'h7FFF, R32767, 1'b0, 1'b1, 4});
    tbl.push_back('{0, 32'h0800, 16'h6800, 1'b0, 1'b0, 7});
    tbl.push_back('{0, 32'h0801, 16'h6800, 1'b0, 1'b1, 7});
    tbl.push_back('{0, 32'h0803, R2051, 1'b0, 1'b1, 7});
    tbl.push_back('{0, 32'hFFFF, 16'hBC00, 1'b0, 1'b0, 18});
    tbl.push_back('{1, 32'hFFFF, RUFFFF, OV_RN, 1'b1, 3});
    tbl.push_back('{1, 32'h8000, 16'h7800, 1'b0, 1'b0, 3});
    tbl.push_back('{2, 32'h0000FFE0, 16'h7BFF, 1'b0, 1'b0, 19});
    tbl.push_back('{2, 32'h0000FFF0, R65520, OV_RN, 1'b1, 19});
    tbl.push_back('{2, 32'hFFFEEE90, 16'hFC00, 1'b1, 1'b1, 18});
    tbl.push_back('{2, 32'h7FFFFFFF, 16'h7C00, 1'b1, 1'b1, 4});
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset u%0d out_valid", k), 32'(ovld[k]), 0);
      chk($sformatf("reset u%0d out_data", k), 32'(od[k]), 0);
      chk($sformatf("reset u%0d overflow", k), 32'(oof[k]), 0);
      chk($sformatf("reset u%0d inexact", k), 32'(oix[k]), 0);
      chk($sformatf("reset u%0d in_ready", k), 32'(ird[k]), 1);
    end
    foreach (tbl[i]) begin
      start(tbl[i].u, tbl[i].d, lat);
      chk($sformatf("v%0d data", i), 32'(od[tbl[i].u]), 32'(tbl[i].data));
      chk($sformatf("v%0d overflow", i), 32'(oof[tbl[i].u]), 32'(tbl[i].ovf));
      chk($sformatf("v%0d inexact", i), 32'(oix[tbl[i].u]), 32'(tbl[i].inx));
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      take(tbl[i].u);
    end
    start(0, 32'h0005, lat);
    chk("bp latency", 32'(lat), 16);
    idat[0] = 32'h0007;
    iv[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp%0d data", k), 32'(od[0]), 32'h4500);
      chk($sformatf("bp%0d out_valid", k), 32'(ovld[0]), 1);
      chk($sformatf("bp%0d in_ready", k), 32'(ird[0]), 0);
    end
    iv[0] = 1'b0;
    take(0);
    chk("bp release in_ready", 32'(ird[0]), 1);
    chk("bp release out_valid", 32'(ovld[0]), 0);
    @(negedge clk);
    idat[0] = 32'h0001;
    iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort in_ready", 32'(ird[0]), 1);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | ovld[0];
    end
    chk("abort out_valid", 32'(seen), 0);
    start(0, 32'h0003, lat);
    chk("after abort data", 32'(od[0]), 32'h4200);
    chk("after abort latency", 32'(lat), 17);
    chk("after abort inexact", 32'(oix[0]), 0);
    take(0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/int2fp_conv.md
# int2fp_conv

Parametrised multi-cycle converter from a signed or unsigned integer to an IEEE 754 binary floating-point word, with configurable exponent and mantissa widths. Integer samples arrive and floats leave over valid/ready handshakes. Normalisation is a serial shift, one bit per clock. Results are rounded, and overflow saturates to infinity with status flags. It is the general replacement for the fixed 16-bit half-precision converter FSM in the datapath front end.

## Interface
- `IN_W`, 16: integer input width; must be ≥ 2.
- `SIGNED`, 1: 1 means the input is two's complement; 0 means unsigned.
- `EXP_W`, 5: exponent field width; must be ≥ 2.
- `MAN_W`, 10: stored mantissa (fraction) width; must be ≥ 1.
- `clk` input, 1 bit: clock; all logic is on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `in_valid` input, 1 bit: an integer sample is offered.
- `in_ready` output, 1 bit: the block can accept a sample; high only in IDLE.
- `in_data` input, `IN_W` bits: the integer sample.
- `out_valid` output, 1 bit: a result is held on the outputs.
- `out_ready` input, 1 bit: the consumer takes the result.
- `out_data` output, `1+EXP_W+MAN_W` bits: {sign, exponent, fraction}.
- `out_overflow` output, 1 bit: the magnitude exceeded the largest finite value, so the result is ±inf.
- `out_inexact` output, 1 bit: nonzero bits were discarded, or overflow occurred.

## Operation
- `BIAS = 2^(EXP_W-1) - 1`.
- **States:** IDLE, ABS, NORM, PACK, DONE.
- **IDLE:**
  - `in_ready` = 1.
  - When `in_valid` is high, capture `in_data`, then go to ABS.
- **ABS:**
  - `sign = SIGNED & in_data[IN_W-1]`.
  - `mag` is an `IN_W`-bit unsigned value: the two's-complement negation when `sign` = 1, otherwise the input itself.
  - The most negative input, -2^(IN_W-1), gives `mag` = 2^(IN_W-1); this is valid and needs no extra bit.
  - Clear the shift counter `sh` (width `$clog2(IN_W)`).
  - If `mag` = 0, set the zero flag and go to PACK; otherwise go to NORM.
- **NORM:**
  - If `mag[IN_W-1]` = 1, go to PACK.
  - Otherwise shift `mag` left by 1, increment `sh`, and stay in NORM.
  - NORM occupies `sh+1` cycles.
- **PACK:** one combinational round-and-pack step, registered into the outputs, then go to DONE.
  - Unbiased exponent `e = IN_W - 1 - sh`.
  - Fraction: `mag[IN_W-2 : 0]`, left-aligned into `MAN_W` bits and zero-padded if `IN_W-1 < MAN_W`.
  - Guard bit `G`: the first discarded bit.
  - Sticky bit `S`: the OR of the remaining discarded bits.
  - Rounding follows the Configuration section.
  - A mantissa carry-out increments `e` and clears the fraction.
  - If `e + BIAS ≥ 2^EXP_W - 1`: output ±inf (all-ones exponent, zero fraction), `overflow` = 1, `inexact` = 1.
  - Otherwise, `inexact` = G | S.
  - Zero input gives +0 with all flags 0.
- **DONE:**
  - `out_valid` = 1, and the outputs are stable.
  - When `out_ready` is high, drop `out_valid` and go to IDLE.
  - No new sample is accepted in the same cycle, because `in_ready` is 0 in DONE.
- Denormal outputs never occur, because the integer magnitude is ≥ 1.

## Timing
- **Reset values:** state IDLE, `out_valid` 0, `out_data` 0, both flags 0. `in_ready` is 1 in the cycle after reset.
- **Reset mid-operation:** the operation is aborted with no output, and the block returns to IDLE.
- **Nonzero latency:** `out_valid` rises after the (3+`sh`)-th edge following the accepting edge. The worst case is `IN_W+2`.
- **Zero latency:** `out_valid` rises after the 2nd edge following the accepting edge.
- **Back-pressure:** the block holds DONE indefinitely while `out_ready` = 0.
- **Throughput:** at most one conversion in flight.
- **Output stability:** `out_data` and the flags change only on the PACK→DONE edge and on reset.

## Configuration
- `INT2FP_ROUND_NEAREST_EN` defined: round to nearest, ties to even. The block increments the mantissa when G & (S | lsb).
- Macro undefined: truncation toward zero. The block never increments, but `inexact` is still reported.
- Overflow detection is identical in both builds.

## Structure
- Package `int2fp_pkg` contains:
  - the state enum `int2fp_state_t`;
  - the function `int2fp_bias(EXP_W)`;
  - the function `int2fp_out_w(EXP_W, MAN_W)`.
- Sub-module `int2fp_round_pack`: combinational. It takes sign, normalised `mag`, `sh` and the zero flag, and produces the packed word, `overflow` and `inexact`. The macro acts only in this sub-module.

## Test plan
All cases use default parameters unless stated; both macro builds are run.
- **Small values:** `in_data` 1 -> 0x3C00; `in_data` -5 (0xFFFB) -> 0xC500; flags 0.
- **Most negative and zero:**
  - `in_data` 0x8000 -> 0xF800 at latency 3.
  - `in_data` 0 -> 0x0000 at latency 2.
- **Rounding:** `in_data` 32767 gives `inexact` = 1 in both builds.
  - With the macro: 0x7800.
  - Without the macro: 0x77FF.
- **Overflow** (`IN_W`=32, `SIGNED`=1): checks that need the macro defined.
  - `in_data` 65504 -> 0x7BFF, exact.
  - `in_data` 65520 -> 0x7C00 with `overflow` = 1.
  - `in_data` -70000 -> 0xFC00 with `overflow` = 1.
- **Unsigned** (`SIGNED`=0): `in_data` 0xFFFF -> sign 0, 0x7C00, `overflow` = 1 (macro defined; 0x7BFF is 65504, the largest finite value, so truncation cannot reach inf).
- **Handshake and reset:**
  - Hold `out_ready` = 0 for 5 cycles: outputs stable, `in_ready` = 0.
  - Assert `reset` during NORM: `out_valid` stays 0, and the next sample converts correctly.
